// File: rtl/sparc_exu_yreg_file_if.sv
// Y-register file bundle: read select/data, W/G writes,
// MULScc shift, pending and collision status.
interface sparc_exu_yreg_file_if #(
  parameter int NTHR  = 4,
  parameter int WIDTH = 32
);
  logic [NTHR-1:0]  thr_e;
  logic [WIDTH-1:0] y_e;
  logic [NTHR-1:0]  y_lsb;
  logic             wr_w_vld;
  logic [NTHR-1:0]  wr_w_thr;
  logic [WIDTH-1:0] wr_w_data;
  logic             wr_g_vld;
  logic [NTHR-1:0]  wr_g_thr;
  logic [WIDTH-1:0] wr_g_data;
  logic             shift_g_vld;
  logic [NTHR-1:0]  shift_g_thr;
  logic             shift_g_bit;
  logic [NTHR-1:0]  y_pend;
  logic             collide_err;
  logic [NTHR-1:0]  collide_thr;

  modport master (
    output thr_e,
    output wr_w_vld, wr_w_thr, wr_w_data,
    output wr_g_vld, wr_g_thr, wr_g_data,
    output shift_g_vld, shift_g_thr,
    output shift_g_bit,
    input  y_e, y_lsb, y_pend,
    input  collide_err, collide_thr
  );

  modport slave (
    input  thr_e,
    input  wr_w_vld, wr_w_thr, wr_w_data,
    input  wr_g_vld, wr_g_thr, wr_g_data,
    input  shift_g_vld, shift_g_thr,
    input  shift_g_bit,
    output y_e, y_lsb, y_pend,
    output collide_err, collide_thr
  );
endinterface

// File: rtl/sparc_exu_yreg_file.sv
// Per-thread Y registers: W write (via W2), G write,
// MULScc shift, collision report. Ports: clk, rst_l
// (sync, active-low), se, yif (slave). Optional
// YREG_BYPASS_EN: y_e returns the next value.
module sparc_exu_yreg_file #(
  parameter int NTHR  = 4,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_l,
  input logic se,
  sparc_exu_yreg_file_if.slave yif
);

  logic [WIDTH-1:0] yreg [NTHR];
  logic [WIDTH-1:0] nxt  [NTHR];
  logic [WIDTH-1:0] rd   [NTHR];

  logic             w2_vld;
  logic [NTHR-1:0]  w2_thr;
  logic [WIDTH-1:0] w2_data;

  logic [NTHR-1:0]  coll;
  logic             col_err_q;
  logic [NTHR-1:0]  col_thr_q;
  logic [WIDTH-1:0] y_rd;
  logic [NTHR-1:0]  lsb;

  // Scan enable only reaches the flops in the
  // physical flow; it has no functional role.
  logic unused_se;
  assign unused_se = se;

  always_comb begin
    coll = '0;
    for (int t = 0; t < NTHR; t++) begin
      logic w2h, gh, sh;
      w2h = w2_vld & w2_thr[t];
      gh  = yif.wr_g_vld & yif.wr_g_thr[t];
      sh  = yif.shift_g_vld & yif.shift_g_thr[t];
      nxt[t] = yreg[t];
      priority case (1'b1)
        w2h: nxt[t] = w2_data;
        gh:  nxt[t] = yif.wr_g_data;
        sh:  nxt[t] = {yif.shift_g_bit,
                       yreg[t][WIDTH-1:1]};
        default: nxt[t] = yreg[t];
      endcase
      coll[t] = (w2h & (gh | sh)) | (gh & sh);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_l) begin
      w2_vld    <= 1'b0;
      w2_thr    <= '0;
      w2_data   <= '0;
      col_err_q <= 1'b0;
      col_thr_q <= '0;
      for (int t = 0; t < NTHR; t++)
        yreg[t] <= '0;
    end else begin
      w2_vld    <= yif.wr_w_vld;
      w2_thr    <= yif.wr_w_thr;
      w2_data   <= yif.wr_w_data;
      col_err_q <= |coll;
      col_thr_q <= coll;
      for (int t = 0; t < NTHR; t++)
        yreg[t] <= nxt[t];
    end
  end

  // nxt equals yreg for threads not being written,
  // so bypass can read nxt unconditionally.
  always_comb begin
    y_rd = '0;
    lsb  = '0;
    for (int t = 0; t < NTHR; t++) begin
`ifdef YREG_BYPASS_EN
      rd[t] = nxt[t];
`else
      rd[t] = yreg[t];
`endif
      if (yif.thr_e[t])
        y_rd = y_rd | rd[t];
      lsb[t] = yreg[t][0];
    end
  end

  assign yif.y_e         = y_rd;
  assign yif.y_lsb       = lsb;
  assign yif.y_pend      = w2_vld ? w2_thr : '0;
  assign yif.collide_err = col_err_q;
  assign yif.collide_thr = col_thr_q;

endmodule

// File: tb/tb_sparc_exu_yreg_file.sv
// Directed checks of sparc_exu_yreg_file: reset,
// W latency, MULScc, collisions, broadcast (8x64).
module tb_sparc_exu_yreg_file;

`ifdef YREG_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_l = 1'b0;
  logic se = 1'b0;
  int   errs = 0;
  int   chks = 0;

  always #5 clk = ~clk;

  sparc_exu_yreg_file_if #(.NTHR(4), .WIDTH(32)) a();
  sparc_exu_yreg_file_if #(.NTHR(8), .WIDTH(64)) b();

  sparc_exu_yreg_file #(.NTHR(4), .WIDTH(32)) u_a (
    .clk(clk), .rst_l(rst_l), .se(se), .yif(a)
  );

  sparc_exu_yreg_file #(.NTHR(8), .WIDTH(64)) u_b (
    .clk(clk), .rst_l(rst_l), .se(se), .yif(b)
  );

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    chks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h",
               tag, got, exp);
    end
  endtask

  // Move just past the next rising edge.
  task automatic nxt_cyc();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs settle mid-cycle.
  task automatic settle();
    #2;
  endtask

  task automatic clr_a();
    a.wr_w_vld    = 1'b0;
    a.wr_w_thr    = '0;
    a.wr_w_data   = '0;
    a.wr_g_vld    = 1'b0;
    a.wr_g_thr    = '0;
    a.wr_g_data   = '0;
    a.shift_g_vld = 1'b0;
    a.shift_g_thr = '0;
    a.shift_g_bit = 1'b0;
  endtask

  task automatic clr_b();
    b.wr_w_vld    = 1'b0;
    b.wr_w_thr    = '0;
    b.wr_w_data   = '0;
    b.wr_g_vld    = 1'b0;
    b.wr_g_thr    = '0;
    b.wr_g_data   = '0;
    b.shift_g_vld = 1'b0;
    b.shift_g_thr = '0;
    b.shift_g_bit = 1'b0;
  endtask

  initial begin
    clr_a();
    clr_b();
    a.thr_e = '0;
    b.thr_e = '0;
    rst_l = 1'b0;
    nxt_cyc();
    nxt_cyc();
    rst_l = 1'b1;
    settle();
    chk("rst_pend", 64'(a.y_pend), 64'h0);
    chk("rst_cerr", 64'(a.collide_err), 64'h0);
    chk("rst_lsb", 64'(a.y_lsb), 64'h0);

    // G write then reset clears it
    nxt_cyc();
    a.wr_g_vld  = 1'b1;
    a.wr_g_thr  = 4'b0100;
    a.wr_g_data = 32'hDEADBEEF;
    a.thr_e     = 4'b0100;
    nxt_cyc();
    clr_a();
    settle();
    chk("g_wr", 64'(a.y_e), 64'hDEADBEEF);
    nxt_cyc();
    rst_l = 1'b0;
    nxt_cyc();
    rst_l = 1'b1;
    settle();
    chk("rst_ye", 64'(a.y_e), 64'h0);
    chk("rst_lsb2", 64'(a.y_lsb), 64'h0);

    // W write latency on thread 1
    nxt_cyc();
    a.wr_w_vld  = 1'b1;
    a.wr_w_thr  = 4'b0010;
    a.wr_w_data = 32'h12345678;
    a.thr_e     = 4'b0010;
    settle();
    chk("w_pend0", 64'(a.y_pend), 64'h0);
    nxt_cyc();
    clr_a();
    settle();
    chk("w_pend1", 64'(a.y_pend), 64'h2);
    chk("w_ye1", 64'(a.y_e),
        BYP ? 64'h12345678 : 64'h0);
    nxt_cyc();
    settle();
    chk("w_ye2", 64'(a.y_e), 64'h12345678);
    chk("w_pend2", 64'(a.y_pend), 64'h0);

    // MULScc shifts on thread 0
    nxt_cyc();
    a.wr_g_vld  = 1'b1;
    a.wr_g_thr  = 4'b0001;
    a.wr_g_data = 32'h3;
    a.thr_e     = 4'b0001;
    nxt_cyc();
    clr_a();
    a.shift_g_vld = 1'b1;
    a.shift_g_thr = 4'b0001;
    a.shift_g_bit = 1'b1;
    settle();
    chk("sh_lsb0", 64'(a.y_lsb[0]), 64'h1);
    chk("sh_ye0", 64'(a.y_e),
        BYP ? 64'h80000001 : 64'h3);
    nxt_cyc();
    settle();
    chk("sh_lsb1", 64'(a.y_lsb[0]), 64'h1);
    chk("sh_ye1", 64'(a.y_e),
        BYP ? 64'hC0000000 : 64'h80000001);
    nxt_cyc();
    clr_a();
    settle();
    chk("sh_lsb2", 64'(a.y_lsb[0]), 64'h0);
    chk("sh_ye2", 64'(a.y_e), 64'hC0000000);

    // W2 vs G collision on thread 3
    nxt_cyc();
    a.wr_w_vld  = 1'b1;
    a.wr_w_thr  = 4'b1000;
    a.wr_w_data = 32'hAAAA0000;
    a.thr_e     = 4'b1000;
    nxt_cyc();
    clr_a();
    a.wr_g_vld  = 1'b1;
    a.wr_g_thr  = 4'b1000;
    a.wr_g_data = 32'h5555FFFF;
    settle();
    chk("co_pend", 64'(a.y_pend), 64'h8);
    chk("co_err0", 64'(a.collide_err), 64'h0);
    chk("co_ye0", 64'(a.y_e),
        BYP ? 64'hAAAA0000 : 64'h0);
    nxt_cyc();
    clr_a();
    settle();
    chk("co_ye1", 64'(a.y_e), 64'hAAAA0000);
    chk("co_err1", 64'(a.collide_err), 64'h1);
    chk("co_thr1", 64'(a.collide_thr), 64'h8);
    nxt_cyc();
    settle();
    chk("co_err2", 64'(a.collide_err), 64'h0);
    chk("co_thr2", 64'(a.collide_thr), 64'h0);

    // G vs shift collision on thread 0
    nxt_cyc();
    a.wr_g_vld    = 1'b1;
    a.wr_g_thr    = 4'b0001;
    a.wr_g_data   = 32'h00000F0F;
    a.shift_g_vld = 1'b1;
    a.shift_g_thr = 4'b0001;
    a.shift_g_bit = 1'b1;
    a.thr_e       = 4'b0001;
    nxt_cyc();
    clr_a();
    settle();
    chk("gs_ye", 64'(a.y_e), 64'h00000F0F);
    chk("gs_thr", 64'(a.collide_thr), 64'h1);

    // Independent W2 (thr 0) and G (thr 1)
    nxt_cyc();
    a.wr_w_vld  = 1'b1;
    a.wr_w_thr  = 4'b0001;
    a.wr_w_data = 32'h11110000;
    nxt_cyc();
    clr_a();
    a.wr_g_vld  = 1'b1;
    a.wr_g_thr  = 4'b0010;
    a.wr_g_data = 32'h22220000;
    nxt_cyc();
    clr_a();
    a.thr_e = 4'b0001;
    settle();
    chk("in_t0", 64'(a.y_e), 64'h11110000);
    chk("in_err", 64'(a.collide_err), 64'h0);
    a.thr_e = 4'b0010;
    settle();
    chk("in_t1", 64'(a.y_e), 64'h22220000);
    a.thr_e = 4'b0011;
    settle();
    chk("rd_or", 64'(a.y_e), 64'h33330000);
    a.thr_e = 4'b0000;
    settle();
    chk("rd_none", 64'(a.y_e), 64'h0);

    // Reset discards pending W2 and G writes
    nxt_cyc();
    a.wr_w_vld  = 1'b1;
    a.wr_w_thr  = 4'b0100;
    a.wr_w_data = 32'h0000FFFF;
    nxt_cyc();
    clr_a();
    rst_l = 1'b0;
    a.wr_g_vld  = 1'b1;
    a.wr_g_thr  = 4'b1000;
    a.wr_g_data = 32'h5;
    nxt_cyc();
    clr_a();
    rst_l = 1'b1;
    a.thr_e = 4'b1100;
    settle();
    chk("mr_ye", 64'(a.y_e), 64'h0);
    chk("mr_pend", 64'(a.y_pend), 64'h0);

    // Broadcast on the 8x64 instance
    nxt_cyc();
    b.wr_g_vld  = 1'b1;
    b.wr_g_thr  = 8'hFF;
    b.wr_g_data = 64'h1;
    nxt_cyc();
    clr_b();
    settle();
    chk("bc_lsb", 64'(b.y_lsb), 64'hFF);
    chk("bc_none", b.y_e, 64'h0);
    b.thr_e = 8'h80;
    settle();
    chk("bc_t7", b.y_e, 64'h1);
    b.thr_e = 8'hFF;
    settle();
    chk("bc_all", b.y_e, 64'h1);

    $display("Result: errors=%0d of %0d checks",
             errs, chks);
    $finish;
  end

endmodule

// File: doc/sparc_exu_yreg_file.md
# sparc_exu_yreg_file

Parametrised per-thread Y-register file for the EXU multiply/divide datapath, successor to the fixed 4×32 Y-register array. Holds one WIDTH-bit Y register per hardware thread. Accepts an architectural write delayed from W to W2, a multiplier result write at G, and a MULScc right-shift at G. Adds synchronous reset, fixed write priority with collision reporting, a per-thread pending-write indicator and an optional read bypass.

## Interface
Parameters:
- NTHR, 4, number of threads / Y registers (1..8)
- WIDTH, 32, Y register width (≥2)

Ports:
- clk  in  1  core clock; all state updates on rising edge
- rst_l  in  1  reset; synchronous, active-low
- se  in  1  scan enable; passed to flops, no functional effect
- thr_e  in  NTHR  one-hot read thread select (E stage)
- y_e  out  WIDTH  selected Y value
- y_lsb  out  NTHR  bit 0 of every Y register, active-high
- wr_w_vld  in  1  architectural (WRY) write valid at W
- wr_w_thr  in  NTHR  target thread mask for W write
- wr_w_data  in  WIDTH  W write data
- wr_g_vld  in  1  multiplier Y write valid at G
- wr_g_thr  in  NTHR  target thread mask for G write
- wr_g_data  in  WIDTH  multiplier Y data
- shift_g_vld  in  1  MULScc shift valid at G
- shift_g_thr  in  NTHR  target thread mask for shift
- shift_g_bit  in  1  bit shifted into MSB
- y_pend  out  NTHR  W write captured, not yet committed
- collide_err  out  1  one-cycle pulse: a write or shift was dropped
- collide_thr  out  NTHR  threads that lost arbitration

## Operation
- Storage: NTHR × WIDTH flops, yreg[t].
- W2 stage: wr_w_vld/thr/data register into w2_vld/w2_thr/w2_data every cycle. W writes always take one extra cycle.
- Per-thread next value, in priority order:
  1. w2_vld & w2_thr[t] → w2_data
  2. wr_g_vld & wr_g_thr[t] → wr_g_data
  3. shift_g_vld & shift_g_thr[t] → {shift_g_bit, yreg[t][WIDTH-1:1]}
  4. otherwise hold
- Thread masks with several bits set are legal: each flagged thread is written (broadcast).
- Collision: any thread with more than one active source → lower-priority source(s) dropped for that thread. collide_err and collide_thr[t] register the next cycle; both clear the cycle after unless a new collision occurs.
- y_pend = w2_thr when w2_vld, else 0.
- Read: y_e = OR over t of (thr_e[t] ? yreg[t] : 0). thr_e = 0 → y_e = 0; multiple bits set → bitwise OR, no error.
- y_lsb[t] = yreg[t][0], from registered state only, never bypassed.

## Timing
- Reset: rst_l low at a rising edge → all yreg = 0, w2_vld = 0, collide_err = 0, collide_thr = 0. Outputs after that edge: y_e = 0, y_lsb = 0, y_pend = 0.
- Reset mid-operation: a captured W2 write and concurrent G writes/shifts are discarded, not committed.
- W write latency: presented in cycle n → y_pend[t] = 1 in cycle n+1 → yreg updated at end of n+1 → visible on y_e in n+2 (n+1 with bypass).
- G write/shift: presented in cycle n → visible on y_e in cycle n+1 (cycle n with bypass).
- Back-to-back shifts on one thread apply once per cycle, cumulatively.
- Collision in cycle n → collide_err = 1 during cycle n+1 only.

## Configuration
- YREG_BYPASS_EN defined:
  - y_e for thread t returns that thread's next value when it is being written this cycle (winner of the priority mux, including a shift result).
  - Read-after-write distance is zero cycles.
- Undefined:
  - y_e reads registered state only.
  - Control must switch the thread out, or stall on y_pend, until the write commits.

## Test plan
- Reset: write 0xDEADBEEF to thread 2 via G, assert rst_l = 0 for one cycle → y_e (thr_e = 0100) = 0, y_lsb = 0.
- W latency: wr_w thread 1 data 0x12345678 in cycle 0 → y_pend = 0010 in cycle 1; y_e = 0x12345678 in cycle 2 (cycle 1 with bypass).
- MULScc: thread 0 = 0x00000003; shift with bit = 1 for 2 cycles → 0x80000001, then 0xC0000000; y_lsb[0] sequence 1, 1, 0.
- Collision: W2 and G both target thread 3, data 0xAAAA0000 / 0x5555FFFF → yreg[3] = 0xAAAA0000; next cycle collide_err = 1, collide_thr = 1000; following cycle both 0.
- Independent: W2 to thread 0 and G to thread 1 in the same cycle → both committed, collide_err stays 0.
- Broadcast/params: NTHR = 8, WIDTH = 64, G mask 0xFF data 0x1 → all eight y_lsb = 1; thr_e = 0 → y_e = 0.
